// File: rtl/booth_r16_seq_mult_if.sv
// Operand-issue and product-writeback handshake bundle for the radix-16 Booth multiplier.
// The producer/consumer side uses the master modport; the multiplier uses slave.
interface booth_r16_seq_mult_if #(
    parameter int LENGTH = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  signed_i;
    logic [LENGTH-1:0]     a_i;
    logic [LENGTH-1:0]     b_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [2*LENGTH-1:0]   p_o;

    modport slave (
        input  in_valid_i, signed_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, p_o
    );

    modport master (
        output in_valid_i, signed_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, p_o
    );
endinterface

// File: rtl/booth_r16_seq_mult.sv
// Iterative radix-16 Booth multiplier, one digit per cycle; result valid LENGTH/4 (signed) or LENGTH/4+1 (unsigned) cycles after accept.
// Accepts only in IDLE; holds the product in DONE until out_ready_i, with no accept on the handoff edge.
module booth_r16_seq_mult #(
    parameter int LENGTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    booth_r16_seq_mult_if.slave  bus
);
    localparam int PW = 2 * LENGTH;
    localparam int BW = LENGTH + 5;
    localparam int NS = LENGTH / 4;
    localparam int CW = $clog2(NS + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic [BW-1:0]   b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [CW-1:0]   k_q, k_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [4:0]      win;
    logic [4:0]      digit;
    logic            neg;
    logic [3:0]      mag;
    logic [PW-1:0]   pp_mag;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum;
    logic            last;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        acc_d       = acc_q;
        p_d         = p_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        k_d         = k_q;

        // b_q keeps Bx with a zero appended below bit 0, so the low 5 bits are always the current window.
        win    = b_q[4:0];
        digit  = {win[4], win[4:1]} + {4'b0000, win[0]};
        neg    = digit[4];
        mag    = neg ? 4'(-digit) : digit[3:0];
        pp_mag = (mag[0] ? a_q : '0) + (mag[1] ? (a_q << 1) : '0)
               + (mag[2] ? (a_q << 2) : '0) + (mag[3] ? (a_q << 3) : '0);
        pp     = neg ? -pp_mag : pp_mag;
        sum    = acc_q + pp;
        last   = (k_q == (sgn_q ? CW'(NS - 1) : CW'(NS)));

        case (state_q)
            IDLE: begin
                if (bus.in_valid_i && in_ready_q) begin
                    sgn_d   = bus.signed_i;
                    a_d     = {{LENGTH{bus.signed_i & bus.a_i[LENGTH-1]}}, bus.a_i};
                    b_d     = {{4{bus.signed_i & bus.b_i[LENGTH-1]}}, bus.b_i, 1'b0};
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = sum;
                a_d   = a_q << 4;
                b_d   = b_q >> 4;
                k_d   = k_q + CW'(1);
                if (last) begin
                    p_d     = sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.p_o         = p_q;
endmodule
